// File: rtl/cont_pkg.sv
// +-----------------------------------------------------------------------------+
// | cont_pkg : shared state encoding and default width for the cont_desc digit  |
// | Rev 1.0  : initial release                                                  |
// +-----------------------------------------------------------------------------+
`default_nettype none

package cont_pkg;

  localparam int CONT_WIDTH = 4;

  localparam logic [1:0] ST_FREE    = 2'd0;
  localparam logic [1:0] ST_ONESHOT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef enum logic [1:0] {
    S_FREE    = ST_FREE,
    S_ONESHOT = ST_ONESHOT,
    S_DONE    = ST_DONE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cont_desc_nxt.sv
// +-----------------------------------------------------------------------------+
// | cont_desc_nxt : next-count / next-state logic; honours CONT_DESC_AUTORELOAD_EN |
// | Rev 1.0       : initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module cont_desc_nxt
  import cont_pkg::*;
#(
  parameter int WIDTH = CONT_WIDTH
) (
  input  state_t           i_state,
  input  logic [WIDTH-1:0] i_cuenta,
  input  logic             i_e,
  input  logic             i_l,
  input  logic [WIDTH-1:0] i_d,
`ifdef CONT_DESC_AUTORELOAD_EN
  input  logic [WIDTH-1:0] i_reload,
`endif
  output logic [WIDTH-1:0] o_cuenta_nxt,
  output state_t           o_state_nxt
);

  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  always_comb begin
    o_cuenta_nxt = i_cuenta;
    o_state_nxt  = i_state;
    if (i_l) begin
      o_cuenta_nxt = i_d;
      o_state_nxt  = (i_d != C_ZERO) ? S_ONESHOT : S_DONE;
    end else begin
      case (i_state)
        S_FREE: begin
          if (i_e) o_cuenta_nxt = i_cuenta - C_ONE;
        end
        S_ONESHOT: begin
          // A zero count here is unreachable; treat it as terminal rather than wrapping.
          if (i_e) begin
            if (i_cuenta <= C_ONE) begin
              o_cuenta_nxt = C_ZERO;
              o_state_nxt  = S_DONE;
            end else begin
              o_cuenta_nxt = i_cuenta - C_ONE;
            end
          end
        end
        S_DONE: begin
`ifdef CONT_DESC_AUTORELOAD_EN
          if (i_reload == C_ZERO) begin
            o_cuenta_nxt = C_ZERO;
            o_state_nxt  = S_DONE;
          end else begin
            o_cuenta_nxt = i_reload;
            o_state_nxt  = S_ONESHOT;
          end
`else
          o_cuenta_nxt = C_ZERO;
          o_state_nxt  = S_FREE;
`endif
        end
        default: begin
          o_cuenta_nxt = C_ZERO;
          o_state_nxt  = S_FREE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cont_desc.sv
// +-----------------------------------------------------------------------------+
// | cont_desc : cascadable down counter with load and one-shot timer mode       |
// |             (CONT_DESC_AUTORELOAD_EN turns the one-shot into a periodic timer)|
// | Rev 1.0   : initial release                                                 |
// +-----------------------------------------------------------------------------+
`default_nettype none

module cont_desc
  import cont_pkg::*;
#(
  parameter int WIDTH = CONT_WIDTH
) (
  input  logic             CK,
  input  logic             nR,
  input  logic             E,
  input  logic             L,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Cuenta,
  output logic             Bnext,
  output logic             Done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cuenta;
  logic [WIDTH-1:0] w_cuenta_nxt;
  logic             r_done;

`ifdef CONT_DESC_AUTORELOAD_EN
  logic [WIDTH-1:0] r_reload;

  always_ff @(posedge CK or negedge nR) begin
    if (!nR)    r_reload <= '0;
    else if (L) r_reload <= D;
  end
`endif

  cont_desc_nxt #(
    .WIDTH(WIDTH)
  ) u_nxt (
    .i_state     (r_state),
    .i_cuenta    (r_cuenta),
    .i_e         (E),
    .i_l         (L),
    .i_d         (D),
`ifdef CONT_DESC_AUTORELOAD_EN
    .i_reload    (r_reload),
`endif
    .o_cuenta_nxt(w_cuenta_nxt),
    .o_state_nxt (w_state_nxt)
  );

  // Done trails the DONE state by one cycle, so it rises the cycle after Cuenta hits 0.
  always_ff @(posedge CK or negedge nR) begin
    if (!nR) begin
      r_state  <= S_FREE;
      r_cuenta <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cuenta <= w_cuenta_nxt;
      r_done   <= (r_state == S_DONE);
    end
  end

  assign Cuenta = r_cuenta;
  assign Done   = r_done;
  assign Bnext  = E && (r_cuenta == '0) && (r_state == S_FREE);

endmodule

`default_nettype wire
